// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-source look-ahead.
// The request side runs LATENCY ticks ahead of the registered sync/pixel outputs.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned RGB_W    = 12,
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned LATENCY  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  input  logic [RGB_W-1:0]   rgb_in,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               req_valid,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               sof,
  output logic [RGB_W-1:0]   rgb_out
);

  localparam int unsigned H_TOTAL   = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL   = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW        = $clog2(H_TOTAL);
  localparam int unsigned VW        = $clog2(V_TOTAL);
  localparam int unsigned H_ACT_BEG = H_SYNC + H_BP;
  localparam int unsigned H_ACT_END = H_ACT_BEG + H_ACTIVE;
  localparam int unsigned V_ACT_BEG = V_SYNC + V_BP;
  localparam int unsigned V_ACT_END = V_ACT_BEG + V_ACTIVE;
  localparam logic        HS_ON     = (HS_POL != 0);
  localparam logic        VS_ON     = (VS_POL != 0);

  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  int unsigned   h_u, v_u;
  logic          h_last, v_last;
  logic          hs, vs, act, sof0;
  logic [3:0]    flags_now, tail;

  assign h_u    = 32'(h_q);
  assign v_u    = 32'(v_q);
  assign h_last = (h_u == H_TOTAL - 1);
  assign v_last = (v_u == V_TOTAL - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_q <= '0;
        if (v_last) v_q <= '0;
        else        v_q <= v_q + 1'b1;
      end else begin
        h_q <= h_q + 1'b1;
      end
    end
  end

  always_comb begin
    hs        = (h_u < H_SYNC);
    vs        = (v_u < V_SYNC);
    act       = (h_u >= H_ACT_BEG) && (h_u < H_ACT_END) &&
                (v_u >= V_ACT_BEG) && (v_u < V_ACT_END);
    sof0      = (h_u == 0) && (v_u == 0);
    req_valid = act;
    col       = '0;
    row       = '0;
    if (act) begin
      col = COORD_W'(h_u - H_ACT_BEG);
      row = COORD_W'(v_u - V_ACT_BEG);
    end
  end

  assign flags_now = {hs, vs, act, sof0};

  // Flags wait here so the pixel source has LATENCY ticks to answer a request.
  if (LATENCY == 0) begin : g_no_dly
    assign tail = flags_now;
  end else begin : g_dly
    logic [3:0] dly_q [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(LATENCY); i++) dly_q[i] <= '0;
      end else if (pix_en) begin
        dly_q[0] <= flags_now;
        for (int i = 1; i < int'(LATENCY); i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign tail = dly_q[LATENCY-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync   <= ~HS_ON;
      vsync   <= ~VS_ON;
      de      <= 1'b0;
      sof     <= 1'b0;
      rgb_out <= '0;
    end else if (pix_en) begin
      hsync   <= tail[3] ? HS_ON : ~HS_ON;
      vsync   <= tail[2] ? VS_ON : ~VS_ON;
      de      <= tail[1];
      sof     <= tail[0];
      rgb_out <= tail[1] ? rgb_in : '0;
    end else begin
      // sof is a one-clk pulse regardless of pixel-tick spacing
      sof <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing with sparse ticks, a tiny raster
// with inverted polarity and no look-ahead, and a LATENCY=2 registered pixel source.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {hs, vs, act, sof0} for a raster position
  function automatic logic [3:0] pos_flags(input int h, input int v, input int hsw, input int hbp,
                                           input int hact, input int vsw, input int vbp,
                                           input int vact);
    logic [3:0] f;
    f[3] = (h < hsw);
    f[2] = (v < vsw);
    f[1] = (h >= hsw + hbp) && (h < hsw + hbp + hact) && (v >= vsw + vbp) &&
           (v < vsw + vbp + vact);
    f[0] = (h == 0) && (v == 0);
    return f;
  endfunction

  // default timing, LATENCY=1, sparse ticks
  logic        d_rst = 1'b1, d_pe = 1'b0;
  logic [11:0] d_rgb_in;
  logic [9:0]  d_row, d_col;
  logic        d_rv, d_hs, d_vs, d_de, d_sof;
  logic [11:0] d_rgb;
  assign d_rgb_in = 12'hABC;

  vga_timing_gen u_def (
    .clk(clk), .reset(d_rst), .pix_en(d_pe), .rgb_in(d_rgb_in), .row(d_row), .col(d_col),
    .req_valid(d_rv), .hsync(d_hs), .vsync(d_vs), .de(d_de), .sof(d_sof), .rgb_out(d_rgb)
  );

  // tiny raster, active-high syncs, LATENCY=0
  logic        t_rst = 1'b1, t_pe = 1'b0;
  logic [11:0] t_rgb_in;
  logic [3:0]  t_row, t_col;
  logic        t_rv, t_hs, t_vs, t_de, t_sof;
  logic [11:0] t_rgb;
  assign t_rgb_in = {4'h5, t_row, t_col};

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .RGB_W(12), .COORD_W(4), .LATENCY(0)
  ) u_tiny (
    .clk(clk), .reset(t_rst), .pix_en(t_pe), .rgb_in(t_rgb_in), .row(t_row), .col(t_col),
    .req_valid(t_rv), .hsync(t_hs), .vsync(t_vs), .de(t_de), .sof(t_sof), .rgb_out(t_rgb)
  );

  // default timing, LATENCY=2 with a two-stage registered pixel source
  logic        l_rst = 1'b1, l_pe = 1'b0;
  logic [11:0] l_rgb_in, src1, src2;
  logic [9:0]  l_row, l_col;
  logic        l_rv, l_hs, l_vs, l_de, l_sof;
  logic [11:0] l_rgb;
  assign l_rgb_in = src2;

  always @(posedge clk) begin
    if (l_pe) begin
      src1 <= {l_col[5:0], l_row[5:0]};
      src2 <= src1;
    end
  end

  vga_timing_gen #(.LATENCY(2)) u_lat2 (
    .clk(clk), .reset(l_rst), .pix_en(l_pe), .rgb_in(l_rgb_in), .row(l_row), .col(l_col),
    .req_valid(l_rv), .hsync(l_hs), .vsync(l_vs), .de(l_de), .sof(l_sof), .rgb_out(l_rgb)
  );

  int d_bad = 0, d_chg = 0, d_hold_sof = 0, d_hs_low = 0;

  task automatic d_tick();
    repeat (2) @(negedge clk);
    @(negedge clk) d_pe = 1'b1;
    @(negedge clk) d_pe = 1'b0;
  endtask

  task automatic hold_def();
    logic [36:0] snap;
    snap = {d_hs, d_vs, d_de, d_sof, d_rgb, d_rv, d_row, d_col};
    repeat (50) begin
      @(negedge clk);
      if ({d_hs, d_vs, d_de, d_sof, d_rgb, d_rv, d_row, d_col} !== snap) d_chg++;
      if (d_sof) d_hold_sof++;
    end
  endtask

  initial begin
    int t_bad_req, t_bad_out, n_sof, hs_cnt, vs_cnt, de_cnt;
    int l_bad, l_vs_low, l_de35, l_sofs;
    int ph, pv, q, qh, qv;
    int sof_t[$];
    logic [3:0]  f;
    logic [8:0]  t_exp_req;
    logic [15:0] exp_o;
    logic [20:0] l_exp_req;
    t_bad_req = 0; t_bad_out = 0; n_sof = 0; hs_cnt = 0; vs_cnt = 0; de_cnt = 0;
    l_bad = 0; l_vs_low = 0; l_de35 = 0; l_sofs = 0;

    // reset values
    #12;
    check("def rst hsync", 32'(d_hs), 1);
    check("def rst vsync", 32'(d_vs), 1);
    check("def rst de", 32'(d_de), 0);
    check("def rst sof", 32'(d_sof), 0);
    check("def rst rgb", 32'(d_rgb), 0);
    check("def rst req", 32'({d_rv, d_row, d_col}), 0);
    check("tiny rst hsync", 32'(t_hs), 0);
    check("tiny rst vsync", 32'(t_vs), 0);
    @(negedge clk);
    d_rst = 1'b0; t_rst = 1'b0; l_rst = 1'b0;

    // tiny raster: H_TOTAL=8, V_TOTAL=6, continuous ticks
    t_pe = 1'b1;
    for (int j = 1; j <= 116; j++) begin
      @(negedge clk);
      ph = j % 8;
      pv = (j / 8) % 6;
      f  = pos_flags(ph, pv, 2, 1, 4, 1, 1, 3);
      t_exp_req = f[1] ? {1'b1, 4'(pv - 2), 4'(ph - 3)} : 9'h0;
      if ({t_rv, t_row, t_col} !== t_exp_req) t_bad_req++;
      q  = j - 1;
      qh = q % 8;
      qv = (q / 8) % 6;
      f  = pos_flags(qh, qv, 2, 1, 4, 1, 1, 3);
      exp_o = {f, f[1] ? {4'h5, 4'(qv - 2), 4'(qh - 3)} : 12'h0};
      if ({t_hs, t_vs, t_de, t_sof, t_rgb} !== exp_o) t_bad_out++;
      if (t_sof) begin
        n_sof++;
        sof_t.push_back(j);
      end
      if (j <= 48) begin
        if (t_hs) hs_cnt++;
        if (t_vs) vs_cnt++;
        if (t_de) de_cnt++;
      end
      if (j < 48 && pv == 2) begin
        if (ph == 3) check("tiny col at h3", 32'(t_col), 0);
        if (ph == 6) check("tiny col at h6", 32'(t_col), 3);
        if (ph == 7) check("tiny col wrap at h7", 32'({t_rv, t_col}), 0);
      end
    end
    check("tiny request errors", 32'(t_bad_req), 0);
    check("tiny output errors", 32'(t_bad_out), 0);
    check("tiny hsync high ticks/frame", 32'(hs_cnt), 12);
    check("tiny vsync high ticks/frame", 32'(vs_cnt), 8);
    check("tiny de ticks/frame", 32'(de_cnt), 12);
    check("tiny sof count", 32'(n_sof), 3);
    if (sof_t.size() >= 2) check("tiny sof period", 32'(sof_t[1] - sof_t[0]), 48);
    else check("tiny sof period", 32'(sof_t.size()), 2);

    // mid-frame asynchronous reset at h=4, v=2
    check("tiny pre-reset req", 32'({t_rv, t_row, t_col}), 32'({1'b1, 4'd0, 4'd1}));
    check("tiny pre-reset de", 32'(t_de), 1);
    #2 t_rst = 1'b1;
    #1;
    check("tiny async rst outputs", 32'({t_hs, t_vs, t_de, t_sof, t_rgb}), 0);
    check("tiny async rst req", 32'({t_rv, t_row, t_col}), 0);
    @(negedge clk) t_rst = 1'b0;
    @(negedge clk);
    check("tiny first sof after reset", 32'(t_sof), 1);
    t_pe = 1'b0;

    // default timing, one tick every 4 clks
    d_tick();
    check("def tick1 sof", 32'(d_sof), 0);
    check("def tick1 hsync blank", 32'(d_hs), 1);
    d_tick();
    check("def tick2 first sof", 32'(d_sof), 1);
    check("def tick2 hsync", 32'(d_hs), 0);
    if (!d_hs) d_hs_low++;
    @(negedge clk);
    check("def sof self-clear", 32'(d_sof), 0);
    hold_def();
    for (int k = 3; k <= 803; k++) begin
      d_tick();
      q  = k - 2;
      qh = q % 800;
      qv = (q / 800) % 525;
      f  = pos_flags(qh, qv, 96, 48, 640, 2, 33, 480);
      exp_o = {~f[3], ~f[2], f[1], f[0], f[1] ? 12'hABC : 12'h0};
      if ({d_hs, d_vs, d_de, d_sof, d_rgb} !== exp_o) d_bad++;
      if ({d_rv, d_row, d_col} !== 21'h0) d_bad++;
      if (k <= 801 && !d_hs) d_hs_low++;
      if (k == 400) hold_def();
    end
    check("def hsync low ticks/line", 32'(d_hs_low), 96);
    check("def model errors", 32'(d_bad), 0);
    check("def hold changes", 32'(d_chg), 0);
    check("def sof during hold", 32'(d_hold_sof), 0);

    // LATENCY=2, continuous ticks up to counter position h=152, v=45
    @(negedge clk) l_pe = 1'b1;
    for (int j = 1; j <= 36152; j++) begin
      @(negedge clk);
      ph = j % 800;
      pv = (j / 800) % 525;
      f  = pos_flags(ph, pv, 96, 48, 640, 2, 33, 480);
      l_exp_req = f[1] ? {1'b1, 10'(pv - 35), 10'(ph - 144)} : 21'h0;
      if ({l_rv, l_row, l_col} !== l_exp_req) l_bad++;
      if (j < 3) begin
        exp_o = {4'b1100, 12'h0};
      end else begin
        q  = j - 3;
        qh = q % 800;
        qv = (q / 800) % 525;
        f  = pos_flags(qh, qv, 96, 48, 640, 2, 33, 480);
        exp_o = {~f[3], ~f[2], f[1], f[0], f[1] ? {6'(qh - 144), 6'(qv - 35)} : 12'h0};
        if (q < 2000 && !l_vs) l_vs_low++;
        if (qv == 35 && l_de) l_de35++;
        if (qh == 144 && qv == 45) check("lat2 rgb row10 first pixel", 32'(l_rgb), 32'h00A);
      end
      if (l_sof) l_sofs++;
      if ({l_hs, l_vs, l_de, l_sof, l_rgb} !== exp_o) l_bad++;
    end
    check("lat2 model errors", 32'(l_bad), 0);
    check("lat2 vsync low ticks", 32'(l_vs_low), 1600);
    check("lat2 de ticks on line 35", 32'(l_de35), 640);
    check("lat2 sof count", 32'(l_sofs), 1);
    check("lat2 pre-reset req", 32'({l_rv, l_row, l_col}), 32'({1'b1, 10'd10, 10'd8}));
    check("lat2 pre-reset rgb", 32'(l_rgb), 32'h14A);

    #2 l_rst = 1'b1;
    #1;
    check("lat2 async rst outputs", 32'({l_hs, l_vs, l_de, l_sof, l_rgb}), 32'h0000C000);
    check("lat2 async rst req", 32'({l_rv, l_row, l_col}), 0);
    @(negedge clk) l_rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("lat2 sof after reset", 32'(l_sof), 32'(i == 3));
    end
    l_pe = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator and pixel pipeline for VGA-style displays. It replaces the fixed 640x480 driver with generic porch, sync and active timings, programmable sync polarity and a pixel-clock enable, and emits frame and line markers. It also adds a configurable look-ahead, so a pixel source with LATENCY pixel-ticks of delay (for example a synchronous ROM or framebuffer read) lines up exactly with the sync outputs. It sits between the clock divider / pixel sources and the board VGA pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- RGB_W, 12, pixel data width
- COORD_W, 10, row/col width; must hold H_ACTIVE-1 and V_ACTIVE-1
- LATENCY, 1, pixel-source delay in pix_en ticks, legal range 0..4
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel tick strobe; all state advances only on clk edges with pix_en=1
- rgb_in  in  RGB_W  pixel data for the coordinate issued LATENCY ticks earlier
- row  out  COORD_W  active-area line of the current request, 0 when req_valid=0
- col  out  COORD_W  active-area pixel of the current request, 0 when req_valid=0
- req_valid  out  1  current counter position is inside the active area
- hsync  out  1  registered horizontal sync at HS_POL
- vsync  out  1  registered vertical sync at VS_POL
- de  out  1  registered data enable (output pixel is active)
- sof  out  1  registered start-of-frame marker
- rgb_out  out  RGB_W  registered pixel; rgb_in when de, else 0

## Operation
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP. Counter widths are $clog2(total).
- Line order is sync, back porch, active, front porch; frame order is the same in lines.
- Horizontal counter h runs 0..H_TOTAL-1. At h=H_TOTAL-1 it wraps to 0 and v increments. At v=V_TOTAL-1 with h=H_TOTAL-1, both wrap to 0.
- Position flags, all combinational from (h,v):
  - hs = h<H_SYNC
  - vs = v<V_SYNC
  - act = H_SYNC+H_BP <= h < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= v < V_SYNC+V_BP+V_ACTIVE
  - sof0 = (h==0 and v==0)
- Request side (combinational): req_valid=act. col = h-(H_SYNC+H_BP) and row = v-(V_SYNC+V_BP) when act, else both 0.
- Delay line: LATENCY stages of {hs, vs, act, sof0}, shifted on pix_en. LATENCY=0 means no stages.
- Output register, loaded on pix_en from the delay-line tail:
  - hsync = hs ? HS_POL : ~HS_POL
  - vsync = vs ? VS_POL : ~VS_POL
  - de = act
  - sof = sof0
  - rgb_out = act ? rgb_in : 0
- sof stays high for exactly one clk. It is cleared on the next clk edge even if pix_en=0.
- pix_en=0 holds every register except sof's self-clear.

## Timing
- Reset (asynchronous, immediate, including mid-frame): h=0, v=0, all delay stages 0, hsync=~HS_POL, vsync=~VS_POL, de=0, sof=0, rgb_out=0. Consequently row=0, col=0, req_valid=0.
- First tick after reset: the output register loads from delay-stage contents, which are all inactive. The sync outputs therefore go active only after LATENCY+1 ticks; this blanking transient is expected.
- Latency: the position present at counter tick t appears on hsync/vsync/de/sof after the pix_en edge at tick t+LATENCY, i.e. 1+LATENCY ticks.
- Pixel source contract: for the coordinate issued at tick t, rgb_in must be valid in the clk cycle of tick t+LATENCY, when it is sampled.
- pix_en may be continuous (one pixel per clk) or sparse. Sparse spacing may be irregular.
- Frame period is H_TOTAL*V_TOTAL ticks; defaults give 800*525 = 420000.

## Test plan
- Reset check: assert reset mid-frame (h=300, v=200) -> all outputs at reset values in the same cycle with no clk edge. After release, the first sof appears at tick 1+LATENCY.
- Default params, pix_en every 4th clk, LATENCY=1 -> hsync low for 96 ticks per 800-tick line; vsync low for 2 lines (1600 ticks) per 420000-tick frame; de high 640 ticks per line on 480 lines.
- LATENCY=2, rgb_in from a 2-stage registered function {col[5:0],row[5:0]} -> each de=1 output carries the function of its own position. At the first active pixel of line 10, rgb_out=12'h00A.
- Tiny params (H 4/1/2/1, V 3/1/1/1), pix_en=1, LATENCY=0 -> H_TOTAL=8, V_TOTAL=6. col runs 0..3 at h=3..6, wraps at h=7 to 0, and sof repeats every 48 clk.
- HS_POL=1, VS_POL=1 -> sync pulses are high with the same widths. Reset value hsync=0, vsync=0.
- pix_en held low 50 clk mid-line -> no output changes, and sof does not re-assert. Sequencing resumes at the exact next position.
